// File: rtl/alu_serial_pkg.sv
// Shared constants for the digit-serial ALU: control-code encodings,
// FSM state encodings and a small decode helper.
package alu_serial_pkg;

    typedef logic [1:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD = 2'b00;
    localparam alu_ctrl_t ALU_SUB = 2'b01;
    localparam alu_ctrl_t ALU_AND = 2'b10;
    localparam alu_ctrl_t ALU_OR  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_arith(input alu_ctrl_t ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational DIGIT-bit ALU slice. For subtraction the caller supplies an
// already-inverted b and a carry-in of 1 on the first digit.
module alu_digit
    import alu_serial_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    input  alu_ctrl_t        ctrl,
    output logic [DIGIT-1:0] y,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] sum;

    always_comb begin
        chain    = '0;
        sum      = '0;
        chain[0] = cin;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            sum[i]     = a[i] ^ b[i] ^ chain[i];
            chain[i+1] = (a[i] & b[i]) | (a[i] & chain[i]) | (b[i] & chain[i]);
        end
    end

    always_comb begin
        y = sum;
        unique case (ctrl)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = sum;
        endcase
    end

    // Non-arithmetic ops pass the carry through untouched.
    assign cout  = is_arith(ctrl) ? chain[DIGIT] : cin;
    assign c_msb = chain[DIGIT-1];

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: accepts one op per input handshake, processes DIGIT bits
// per cycle LSB first, and presents result plus flags on an output handshake.
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    alu_ctrl_t        ctrl_q, ctrl_d;
    logic             carry_q, carry_d;
    logic             zacc_q, zacc_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             cflag_q, cflag_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_y;
    logic             dig_cout;
    logic             dig_cmsb;

    alu_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .ctrl (ctrl_q),
        .y    (dig_y),
        .cout (dig_cout),
        .c_msb(dig_cmsb)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ctrl_d  = ctrl_q;
        carry_d = carry_q;
        zacc_d  = zacc_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        cflag_d = cflag_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = src_a;
                    b_d     = (ALUctrl == ALU_SUB) ? ~src_b : src_b;
                    ctrl_d  = ALUctrl;
                    carry_d = (ALUctrl == ALU_SUB);
                    cnt_d   = '0;
                    zacc_d  = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                res_d  = {dig_y, res_q[WIDTH-1:DIGIT]};
                a_d    = a_q >> DIGIT;
                b_d    = b_q >> DIGIT;
                zacc_d = zacc_q | (|dig_y);
                cnt_d  = cnt_q + CW'(1);
                if (is_arith(ctrl_q)) begin
                    carry_d = dig_cout;
                end
                // Last digit: its slice holds the MSB, so all flags resolve here.
                if (cnt_q == LAST) begin
                    zero_d  = ~(zacc_q | (|dig_y));
                    neg_d   = dig_y[DIGIT-1];
                    cflag_d = is_arith(ctrl_q) ? dig_cout : 1'b0;
                    ovf_d   = is_arith(ctrl_q) ? (dig_cmsb ^ dig_cout) : 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ctrl_q  <= ALU_ADD;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            cflag_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ctrl_q  <= ctrl_d;
            carry_q <= carry_d;
            zacc_q  <= zacc_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            cflag_q <= cflag_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = res_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign carry     = cflag_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_serial.sv
// Directed-vector bench for alu_serial with hand-computed expected results.
module tb_alu_serial;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALUctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    alu_serial #(
        .WIDTH(32),
        .DIGIT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ALUctrl  (ALUctrl),
        .src_a    (src_a),
        .src_b    (src_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .negative (negative),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // flags = {zero, negative, carry, overflow}
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic [3:0] flags,
                          input int hold, input bit mess);
        int t;
        int lat;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        ALUctrl  = op;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = mess;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
            if (mess) begin
                src_a    = $urandom;
                src_b    = $urandom;
                ALUctrl  = 2'($urandom_range(0, 3));
                in_valid = ~in_valid;
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_result"}, result, exp_r);
        check({tag, "_flags"}, {28'd0, zero, negative, carry, overflow}, {28'd0, flags});
        check({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            if (mess) begin
                src_a    = $urandom;
                ALUctrl  = 2'($urandom_range(0, 3));
                in_valid = ~in_valid;
            end
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_result"}, result, exp_r);
            check({tag, "_hold_flags"}, {28'd0, zero, negative, carry, overflow}, {28'd0, flags});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ALUctrl   = 2'b00;
        src_a     = '0;
        src_b     = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {28'd0, zero, negative, carry, overflow}, 32'd0);

        run_op("add_5_3",    2'b00, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 4'b0000, 0, 0);
        run_op("sub_7_7",    2'b01, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 4'b1010, 0, 0);
        run_op("sub_0_1",    2'b01, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0100, 0, 0);
        run_op("add_ovf",    2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101, 0, 0);
        run_op("add_wrap",   2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010, 0, 0);
        run_op("and",        2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0100, 0, 0);
        run_op("or",         2'b11, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 4'b0100, 0, 0);
        run_op("sub_signed", 2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011, 0, 0);
        run_op("bp_add",     2'b00, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 4'b0000, 5, 1);

        // Asynchronous reset after three digits of an add.
        ALUctrl  = 2'b00;
        src_a    = 32'h0000_00FF;
        src_b    = 32'h0000_0001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_flags", {28'd0, zero, negative, carry, overflow}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        run_op("after_rst", 2'b00, 32'h0000_000A, 32'h0000_0006, 32'h0000_0010, 4'b0000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_serial.md
# alu_serial

Digit-serial ALU that executes the operation selected by the 2-bit ALU control code (add, sub, and, or) over several cycles, processing DIGIT bits per cycle to save area. It is the consumer of the ALU control code, used in area-reduced or multi-cycle datapath variants. It accepts one operation per valid/ready handshake. It returns the result and condition flags on a second valid/ready handshake.

## Interface
- WIDTH, 32, operand/result width in bits.
- DIGIT, 4, bits processed per cycle; WIDTH % DIGIT == 0 is required. N = WIDTH/DIGIT.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- ALUctrl  input  2  00 add, 01 sub, 10 and, 11 or.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B.
- out_valid  output  1  result and flags valid; high only in DONE.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].
- carry  output  1  add: carry out of MSB. Sub: NOT borrow, i.e. 1 iff src_a >= src_b unsigned. And/or: 0.
- overflow  output  1  signed overflow for add/sub; 0 for and/or.

## Operation
- The FSM has three states: IDLE, BUSY and DONE. Reset enters IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid, the block captures src_a, src_b and ALUctrl.
  - For sub it stores ~src_b and presets carry_reg = 1. Otherwise carry_reg = 0.
  - It clears the digit counter and zero accumulator, then goes to BUSY.
- BUSY:
  - Each cycle one DIGIT-wide slice computes the low DIGIT bits of the A and B shift registers with carry_reg.
  - The slice output is shifted into the top of the result register, LSB digit first. A and B shift right by DIGIT.
  - carry_reg is updated only for add/sub.
  - The zero accumulator ORs in the slice output.
  - On the N-th digit, the block computes overflow as the carry into the MSB XOR the carry out of the MSB, then goes to DONE.
- DONE:
  - out_valid = 1. result and all flags are held stable.
  - On out_ready the block returns to IDLE.
- Inputs are ignored outside IDLE; changes to src_a, src_b or ALUctrl after acceptance have no effect.
- All arithmetic is modulo 2^WIDTH.

## Timing
- Reset values: in_ready = 1, out_valid = 0, result = 0, zero = 0, negative = 0, carry = 0, overflow = 0. Counter and state are cleared.
- Reset at any point, including mid-BUSY or in DONE, aborts the operation with no output. in_ready is 1 in the first cycle after reset deasserts.
- Acceptance occurs at edge E0 (in_valid & in_ready). out_valid rises after edge E0+N.
- A DONE handshake at edge Ed sets in_ready = 1 in the following cycle. With constant valid/ready the throughput is one operation per N+2 cycles.
- out_valid stays high with stable outputs for as long as out_ready is low.
- in_ready and out_valid are never high in the same cycle.
- in_ready and out_valid decode directly from the state register, with no combinational path from inputs.

## Structure
- A shared package holds:
  - the ALU control encodings ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_OR = 2'b11, which the control-code decoder also uses;
  - the FSM state encoding IDLE/BUSY/DONE.
- Sub-module alu_digit is a combinational DIGIT-bit slice. Inputs: a, b (pre-inverted for sub), cin, ctrl. Outputs: y, cout, and the carry into its MSB for overflow.
- The top level contains the FSM, the $clog2(N)-bit digit counter, the shift registers, carry_reg and the flag registers.

## Test plan
All scenarios use WIDTH = 32, DIGIT = 4, N = 8.
- add 0x00000005 + 0x00000003 → result 0x00000008, zero 0, carry 0, overflow 0; out_valid rises exactly 8 cycles after acceptance.
- sub 0x00000007 − 0x00000007 → result 0, zero 1, carry 1. Then sub 0 − 1 → 0xFFFFFFFF, negative 1, carry 0, overflow 0.
- add 0x7FFFFFFF + 1 → 0x80000000, overflow 1, negative 1. Then add 0xFFFFFFFF + 1 → 0, carry 1, zero 1.
- and 0xF0F0F0F0, 0xFF00FF00 → 0xF000F000. Then or with the same operands → 0xFFF0FFF0. Both give carry 0 and overflow 0.
- Backpressure: hold out_ready low 5 cycles in DONE → outputs stable and in_ready 0 throughout. Toggling in_valid, src_a and ALUctrl during BUSY/DONE does not alter the result.
- Reset asserted asynchronously after digit 3 of an add → out_valid 0 immediately, all outputs 0. The next request completes correctly in 8 cycles.
